// File: rtl/rtp_collect_pkg.sv
// rtp_collect_pkg
//   Shared types and widths for the multi-channel RTP result collector.
//   Run-state enum, counter widths and the default-width result record.
//   Optional macro RTP_CYCLE_STAMP_EN adds a cycle stamp field to the record.
package rtp_collect_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam int unsigned HIT_W    = 32;
   localparam int unsigned CNT_W    = 64;
   localparam int unsigned RCNT_W   = 32;
   localparam int unsigned DEF_ID_W = 32;

   // Result record at the default id width; the collector builds the same
   // layout locally with its own ID_W.
   typedef struct packed {
      logic [HIT_W-1:0]    hitT;
      logic [DEF_ID_W-1:0] ray_id;
`ifdef RTP_CYCLE_STAMP_EN
      logic [CNT_W-1:0]    stamp;
`endif
   } rtp_result_t;

endpackage

// File: rtl/rtp_ch_fifo.sv
// rtp_ch_fifo
//   One-channel synchronous FIFO, DEPTH entries (power of 2, >= 2).
//   Ports: clock, reset (sync active-low), push/push_data, pop,
//          full, empty, head (current oldest entry, valid when !empty).
//   Pointers carry one extra wrap bit: equal pointers = empty, equal index
//   with differing wrap bit = full. Push while full and pop while empty are
//   ignored; a full FIFO refuses a push even if it is popped that cycle.
module rtp_ch_fifo #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   always_comb begin
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      wr_d    = wr_q + (AW+1)'(do_push);
      rd_d    = rd_q + (AW+1)'(do_pop);
      head    = mem_q[rd_q[AW-1:0]];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/rtp_result_collector.sv
// rtp_result_collector
//   Collects hit results from N_CH ray-triangle pipelines through per-channel
//   FIFOs and merges them round-robin onto one registered valid/ready stream.
//   Tracks run cycle count and delivered result count; done once every
//   channel has finished and all results are drained.
//   Ports: clock, reset (sync active-low), start, ch_valid/ch_ready/ch_hitT/
//          ch_ray_id/ch_finish (per channel), out_valid/out_ready/out_hitT/
//          out_ray_id/out_ch (merged stream), busy, done, total_cycle,
//          ray_count.
//   Optional macro RTP_CYCLE_STAMP_EN: adds out_stamp, the total_cycle value
//   captured when the beat was pushed into its FIFO.
module rtp_result_collector
   import rtp_collect_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned ID_W  = 32,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [N_CH-1:0]        ch_valid,
   output logic [N_CH-1:0]        ch_ready,
   input  logic [N_CH*HIT_W-1:0]  ch_hitT,
   input  logic [N_CH*ID_W-1:0]   ch_ray_id,
   input  logic [N_CH-1:0]        ch_finish,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [HIT_W-1:0]       out_hitT,
   output logic [ID_W-1:0]        out_ray_id,
   output logic [CH_W-1:0]        out_ch,
`ifdef RTP_CYCLE_STAMP_EN
   output logic [CNT_W-1:0]       out_stamp,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       total_cycle,
   output logic [RCNT_W-1:0]      ray_count
);

   typedef struct packed {
      logic [HIT_W-1:0] hitT;
      logic [ID_W-1:0]  ray_id;
`ifdef RTP_CYCLE_STAMP_EN
      logic [CNT_W-1:0] stamp;
`endif
   } entry_t;

   localparam int unsigned EW = $bits(entry_t);

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           total_cycle_q, total_cycle_d;
   logic [RCNT_W-1:0]          ray_count_q, ray_count_d;
   logic [N_CH-1:0]            fin_q, fin_d;
   logic [CH_W-1:0]            rr_q, rr_d;
   logic                       out_valid_q, out_valid_d;
   logic [HIT_W-1:0]           out_hitT_q, out_hitT_d;
   logic [ID_W-1:0]            out_ray_id_q, out_ray_id_d;
   logic [CH_W-1:0]            out_ch_q, out_ch_d;
`ifdef RTP_CYCLE_STAMP_EN
   logic [CNT_W-1:0]           out_stamp_q, out_stamp_d;
`endif

   logic [N_CH-1:0]            full, empty, push, pop;
   logic [N_CH-1:0][EW-1:0]    head_bits;
   logic                       found;
   logic [CH_W-1:0]            grant;
   logic                       load;
   entry_t                     hd;

   assign busy     = (state_q == RUN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign ch_ready = {N_CH{busy}} & ~full;
   assign push     = ch_valid & ch_ready;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      entry_t pe;
      always_comb begin
         pe        = '0;
         pe.hitT   = ch_hitT[HIT_W*i +: HIT_W];
         pe.ray_id = ch_ray_id[ID_W*i +: ID_W];
`ifdef RTP_CYCLE_STAMP_EN
         pe.stamp  = total_cycle_q;
`endif
      end

      rtp_ch_fifo #(
         .W     (EW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push[i]),
         .push_data (pe),
         .pop       (pop[i]),
         .full      (full[i]),
         .empty     (empty[i]),
         .head      (head_bits[i])
      );
   end

   // First non-empty FIFO at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         int unsigned c;
         c = (32'(rr_q) + k) % N_CH;
         if (!found && !empty[CH_W'(c)]) begin
            found = 1'b1;
            grant = CH_W'(c);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      total_cycle_d = total_cycle_q;
      ray_count_d   = ray_count_q;
      fin_d         = fin_q;
      rr_d          = rr_q;
      out_valid_d   = out_valid_q;
      out_hitT_d    = out_hitT_q;
      out_ray_id_d  = out_ray_id_q;
      out_ch_d      = out_ch_q;
`ifdef RTP_CYCLE_STAMP_EN
      out_stamp_d   = out_stamp_q;
`endif
      pop           = '0;
      hd            = '0;
      load          = !out_valid_q || out_ready;

      if (out_valid_q && out_ready) begin
         ray_count_d = ray_count_q + 1'b1;
      end

      if (load) begin
         out_valid_d = found;
         if (found) begin
            hd           = entry_t'(head_bits[grant]);
            pop[grant]   = 1'b1;
            out_hitT_d   = hd.hitT;
            out_ray_id_d = hd.ray_id;
            out_ch_d     = grant;
`ifdef RTP_CYCLE_STAMP_EN
            out_stamp_d  = hd.stamp;
`endif
            rr_d         = (grant == CH_W'(N_CH-1)) ? '0 : grant + 1'b1;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d       = RUN;
               total_cycle_d = '0;
               ray_count_d   = '0;
               fin_d         = '0;
            end
         end
         RUN: begin
            total_cycle_d = total_cycle_q + 1'b1;
            fin_d         = fin_q | ch_finish;
            if (&fin_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            total_cycle_d = total_cycle_q + 1'b1;
            // A beat pushed this cycle is still in flight, so it blocks DONE.
            if ((&empty) && !(|push) && load) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         total_cycle_q <= '0;
         ray_count_q   <= '0;
         fin_q         <= '0;
         rr_q          <= '0;
         out_valid_q   <= 1'b0;
         out_hitT_q    <= '0;
         out_ray_id_q  <= '0;
         out_ch_q      <= '0;
`ifdef RTP_CYCLE_STAMP_EN
         out_stamp_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         total_cycle_q <= total_cycle_d;
         ray_count_q   <= ray_count_d;
         fin_q         <= fin_d;
         rr_q          <= rr_d;
         out_valid_q   <= out_valid_d;
         out_hitT_q    <= out_hitT_d;
         out_ray_id_q  <= out_ray_id_d;
         out_ch_q      <= out_ch_d;
`ifdef RTP_CYCLE_STAMP_EN
         out_stamp_q   <= out_stamp_d;
`endif
      end
   end

   assign out_valid   = out_valid_q;
   assign out_hitT    = out_hitT_q;
   assign out_ray_id  = out_ray_id_q;
   assign out_ch      = out_ch_q;
`ifdef RTP_CYCLE_STAMP_EN
   assign out_stamp   = out_stamp_q;
`endif
   assign total_cycle = total_cycle_q;
   assign ray_count   = ray_count_q;

endmodule

// File: tb/tb_rtp_result_collector.sv
// tb_rtp_result_collector
//   Drives directed and random traffic into rtp_result_collector and checks
//   every cycle against a queue-based reference model, plus fixed literal
//   expectations for the hand-worked scenarios.
`timescale 1ns/1ps
module tb_rtp_result_collector;

   localparam int N_CH  = 4;
   localparam int ID_W  = 32;
   localparam int DEPTH = 8;
   localparam int CH_W  = 2;

   localparam int PH_IDLE  = 0;
   localparam int PH_RUN   = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_DONE  = 3;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   start = 1'b0;
   logic [N_CH-1:0]        ch_valid = '0;
   logic [N_CH-1:0]        ch_ready;
   logic [N_CH*32-1:0]     ch_hitT = '0;
   logic [N_CH*ID_W-1:0]   ch_ray_id = '0;
   logic [N_CH-1:0]        ch_finish = '0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [31:0]            out_hitT;
   logic [ID_W-1:0]        out_ray_id;
   logic [CH_W-1:0]        out_ch;
`ifdef RTP_CYCLE_STAMP_EN
   logic [63:0]            out_stamp;
`endif
   logic                   busy;
   logic                   done;
   logic [63:0]            total_cycle;
   logic [31:0]            ray_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clock = ~clock;

   rtp_result_collector #(
      .N_CH  (N_CH),
      .ID_W  (ID_W),
      .DEPTH (DEPTH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .ch_valid    (ch_valid),
      .ch_ready    (ch_ready),
      .ch_hitT     (ch_hitT),
      .ch_ray_id   (ch_ray_id),
      .ch_finish   (ch_finish),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_hitT    (out_hitT),
      .out_ray_id  (out_ray_id),
      .out_ch      (out_ch),
`ifdef RTP_CYCLE_STAMP_EN
      .out_stamp   (out_stamp),
`endif
      .busy        (busy),
      .done        (done),
      .total_cycle (total_cycle),
      .ray_count   (ray_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [32+ID_W-1:0] mq [N_CH][$];
   bit                 m_ov;
   logic [31:0]        m_hit;
   logic [ID_W-1:0]    m_id;
   int                 m_ch;
   int                 m_rr;
   logic [N_CH-1:0]    m_fin;
   int                 m_ph;
   logic [63:0]        m_tc;
   logic [31:0]        m_rc;

   initial begin
      m_ov = 0; m_hit = '0; m_id = '0; m_ch = 0; m_rr = 0;
      m_fin = '0; m_ph = PH_IDLE; m_tc = '0; m_rc = '0;
   end

   always @(posedge clock) begin
      bit              m_busy, hs, got, drained;
      logic [N_CH-1:0] nonempty, pushes;
      logic [32+ID_W-1:0] e;
      if (!reset) begin
         for (int c = 0; c < N_CH; c++) mq[c].delete();
         m_ov = 0; m_hit = '0; m_id = '0; m_ch = 0; m_rr = 0;
         m_fin = '0; m_ph = PH_IDLE; m_tc = '0; m_rc = '0;
      end else begin
         m_busy = (m_ph == PH_RUN) || (m_ph == PH_DRAIN);
         for (int c = 0; c < N_CH; c++) begin
            nonempty[c] = (mq[c].size() != 0);
            pushes[c]   = ch_valid[c] && m_busy && (mq[c].size() < DEPTH);
         end
         hs      = m_ov && out_ready;
         drained = (nonempty == '0) && (pushes == '0) && (!m_ov || out_ready);
         if (!m_ov || out_ready) begin
            got = 0;
            for (int k = 0; k < N_CH; k++) begin
               int c;
               c = (m_rr + k) % N_CH;
               if (!got && nonempty[c]) begin
                  got   = 1;
                  e     = mq[c].pop_front();
                  m_hit = e[32+ID_W-1:ID_W];
                  m_id  = e[ID_W-1:0];
                  m_ch  = c;
                  m_rr  = (c + 1) % N_CH;
               end
            end
            m_ov = got;
         end
         for (int c = 0; c < N_CH; c++)
            if (pushes[c]) mq[c].push_back({ch_hitT[32*c +: 32], ch_ray_id[ID_W*c +: ID_W]});
         if (hs) m_rc = m_rc + 1;
         case (m_ph)
            PH_IDLE, PH_DONE: if (start) begin
               m_ph = PH_RUN; m_tc = '0; m_rc = '0; m_fin = '0;
            end
            PH_RUN: begin
               m_tc = m_tc + 1;
               if (&m_fin) m_ph = PH_DRAIN;
               m_fin = m_fin | ch_finish;
            end
            default: begin
               m_tc = m_tc + 1;
               if (drained) m_ph = PH_DONE;
            end
         endcase
      end
   end

   // ---------------- per-cycle compare + delivered-beat log ----------------
   logic [35:0] log_q [$];

   always @(negedge clock) begin
      logic [N_CH-1:0] m_ready;
      if (chk_en) begin
         for (int c = 0; c < N_CH; c++)
            m_ready[c] = ((m_ph == PH_RUN) || (m_ph == PH_DRAIN)) && (mq[c].size() < DEPTH);
         check("cyc_ch_ready", ch_ready, m_ready);
         check("cyc_out_valid", out_valid, m_ov);
         check("cyc_busy", busy, (m_ph == PH_RUN) || (m_ph == PH_DRAIN));
         check("cyc_done", done, m_ph == PH_DONE);
         check("cyc_total_cycle", total_cycle, m_tc);
         check("cyc_ray_count", ray_count, m_rc);
         if (m_ov) begin
            check("cyc_out_hitT", out_hitT, m_hit);
            check("cyc_out_ray_id", out_ray_id, m_id);
            check("cyc_out_ch", out_ch, m_ch);
         end
         if (out_valid && out_ready) log_q.push_back({4'(out_ch), out_hitT});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      start = 0; ch_valid = '0; ch_finish = '0;
      reset = 0;
      tick(1);
      reset = 1;
   endtask

   task automatic wait_done(input int max_cyc);
      int i;
      i = 0;
      while (!done && i < max_cyc) begin
         tick(1);
         i++;
      end
      check("done_reached", done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit acc;

      // Reset and idle
      reset = 0;
      tick(1);
      chk_en = 1;
      tick(2);
      reset = 1;
      ch_valid = '1;
      tick(3);
      check("idle_ch_ready", ch_ready, 0);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_total_cycle", total_cycle, 0);
      check("idle_ray_count", ray_count, 0);
      check("idle_out_hitT", out_hitT, 0);
      check("idle_out_ray_id", out_ray_id, 0);
      check("idle_out_ch", out_ch, 0);
      ch_valid = '0;

      // Single channel
      out_ready = 1; start = 1; tick(1); start = 0;
      ch_valid = 4'b0001; ch_hitT[31:0] = 32'h3F80_0000; ch_ray_id[ID_W-1:0] = ID_W'(5);
      tick(1);
      ch_valid = '0; ch_finish = '1;
      tick(1);
      check("single_out_valid", out_valid, 1);
      check("single_out_hitT", out_hitT, 32'h3F80_0000);
      check("single_out_ray_id", out_ray_id, 5);
      check("single_out_ch", out_ch, 0);
      ch_finish = '0;
      wait_done(20);
      check("single_total_cycle", total_cycle, 4);
      check("single_ray_count", ray_count, 1);
      tick(3);
      check("single_tc_frozen", total_cycle, 4);

      // Round-robin
      do_reset(); log_q.delete();
      out_ready = 1; start = 1; tick(1); start = 0;
      for (int b = 0; b < 2; b++) begin
         ch_valid = '1;
         for (int c = 0; c < N_CH; c++) begin
            ch_hitT[32*c +: 32]      = 32'(c*16 + b);
            ch_ray_id[ID_W*c +: ID_W] = ID_W'(100 + c*16 + b);
         end
         tick(1);
      end
      ch_valid = '0; ch_finish = '1; tick(1); ch_finish = '0;
      wait_done(40);
      check("rr_beats", log_q.size(), 8);
      for (int i = 0; i < log_q.size() && i < 8; i++) begin
         check("rr_ch", log_q[i][35:32], i % 4);
         check("rr_hit", log_q[i][31:0], (i % 4)*16 + i/4);
      end
      check("rr_ray_count", ray_count, 8);

      // Backpressure / full
      do_reset(); log_q.delete();
      out_ready = 0; start = 1; tick(1); start = 0;
      n = 0;
      ch_valid = 4'b0010;
      for (int k = 0; k < 14; k++) begin
         ch_hitT[63:32] = 32'h100 + 32'(n);
         ch_ray_id[2*ID_W-1:ID_W] = ID_W'(n);
         acc = ch_ready[1];
         tick(1);
         if (acc) n++;
      end
      check("bp_accepts", n, 9);
      check("bp_ready_low", ch_ready[1], 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_hitT_stable", out_hitT, 32'h100);
      check("bp_out_ch", out_ch, 1);
      ch_valid = '0; out_ready = 1; ch_finish = '1; tick(1); ch_finish = '0;
      wait_done(40);
      check("bp_beats", log_q.size(), 9);
      for (int i = 0; i < log_q.size() && i < 9; i++)
         check("bp_order", log_q[i], {4'd1, 32'h100 + 32'(i)});

      // Finish with last beat, held in DRAIN
      do_reset(); log_q.delete();
      out_ready = 0; start = 1; tick(1); start = 0;
      ch_finish = 4'b1011; tick(1); ch_finish = '0;
      ch_valid = 4'b0100; ch_finish = 4'b0100; ch_hitT[95:64] = 32'hABC;
      tick(1);
      ch_valid = '0; ch_finish = '0;
      tick(5);
      check("drain_busy", busy, 1);
      check("drain_not_done", done, 0);
      check("drain_out_hitT", out_hitT, 32'hABC);
      check("drain_out_ch", out_ch, 2);
      out_ready = 1; tick(1);
      check("drain_done", done, 1);
      check("drain_ray_count", ray_count, 1);
      check("drain_beats", log_q.size(), 1);
      if (log_q.size() > 0) check("drain_beat", log_q[0], {4'd2, 32'hABC});

      // Reset mid-run, then restart from DONE
      do_reset();
      out_ready = 0; start = 1; tick(1); start = 0;
      ch_valid = 4'b0111;
      ch_hitT[31:0] = 32'h11; ch_hitT[63:32] = 32'h22; ch_hitT[95:64] = 32'h33;
      ch_finish = '1; tick(1);
      ch_valid = '0; ch_finish = '0; tick(2);
      check("mid_busy", busy, 1);
      reset = 0; tick(1); reset = 1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ch_ready", ch_ready, 0);
      check("mid_rst_total_cycle", total_cycle, 0);
      check("mid_rst_ray_count", ray_count, 0);
      out_ready = 1; tick(3);
      check("mid_rst_discard", out_valid, 0);
      start = 1; tick(1); start = 0;
      ch_valid = 4'b0001; ch_hitT[31:0] = 32'h77; tick(1);
      ch_valid = '0; ch_finish = '1; tick(1); ch_finish = '0;
      wait_done(20);
      check("pre_restart_ray_count", ray_count, 1);
      start = 1; tick(1); start = 0;
      check("restart_total_cycle", total_cycle, 0);
      check("restart_ray_count", ray_count, 0);
      check("restart_busy", busy, 1);
      tick(1);
      check("restart_tc_step", total_cycle, 1);
      ch_finish = '1; tick(1); ch_finish = '0;
      wait_done(20);

      // Random runs, started from DONE
      for (int r = 0; r < 3; r++) begin
         start = 1; tick(1); start = 0;
         for (int cyc = 0; cyc < 300; cyc++) begin
            ch_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) begin
               ch_hitT[32*c +: 32]       = $urandom;
               ch_ray_id[ID_W*c +: ID_W] = ID_W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 15) == 0);
            tick(1);
         end
         start = 0; ch_valid = '0; ch_finish = '1; tick(1); ch_finish = '0;
         for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            out_ready = $urandom_range(0, 1);
            tick(1);
         end
         check("rand_done", done, 1);
      end

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rtp_result_collector.md
Name: rtp_result_collector

Overview:
- Multi-channel successor to the single-RTP result/finish/cycle-count observation path.
- Gathers hit results (hitT, ray id) from N_CH ray-triangle pipelines through per-channel FIFOs.
- A round-robin arbiter merges them onto one valid/ready stream.
- Tracks run-wide cycle count and result count, and asserts done once every channel has finished and all results are drained.

Parameters:
- N_CH, 4, number of RTP channels (1..16).
- ID_W, 32, ray/triangle id width.
- DEPTH, 8, per-channel FIFO entries (power of 2, >=2).
- CH_W, $clog2(N_CH) (min 1), channel index width (derived, localparam).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  pulse; clears counters and sticky flags, begins a run.
- ch_valid  in  N_CH  per-channel result valid.
- ch_ready  out  N_CH  per-channel accept.
- ch_hitT  in  N_CH*32  packed hitT, channel i at [32*i+:32].
- ch_ray_id  in  N_CH*ID_W  packed ray/triangle id.
- ch_finish  in  N_CH  channel-complete indication (level or pulse).
- out_valid  out  1  merged result valid.
- out_ready  in  1  downstream accept.
- out_hitT  out  32  merged hitT.
- out_ray_id  out  ID_W  merged id.
- out_ch  out  CH_W  source channel.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- total_cycle  out  64  cycles since start; frozen in DONE.
- ray_count  out  32  results delivered on out_* this run.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; FIFOs are emptied; RR pointer is set to 0; sticky finish flags are cleared.
  - All outputs are 0: ch_ready, out_valid, out_hitT, out_ray_id, out_ch, busy, done, total_cycle, ray_count.
  - Reset mid-run discards all buffered data.
- FSM:
  - IDLE: start -> RUN.
  - RUN: when all sticky finish flags are set -> DRAIN.
  - DRAIN: when all FIFOs are empty and out_valid==0 (or its final beat is handshaking) -> DONE.
  - DONE: start -> RUN.
  - start is ignored in RUN/DRAIN.
- On a start that moves to RUN:
  - total_cycle and ray_count are cleared to 0.
  - Sticky finish flags are cleared.
  - FIFOs and the RR pointer are not touched; they are already empty.
- total_cycle increments by 1 every cycle in RUN and DRAIN, holds otherwise, and wraps at 2^64.
- ray_count increments on each out_valid&&out_ready handshake and wraps at 2^32.
- ch_ready[i] = busy && !full[i]. There is no full-bypass: a full FIFO blocks push even when it is popped in the same cycle.
- Sticky finish[i] sets when ch_finish[i]==1 during RUN. A finish in the same cycle as the channel's last accepted beat is legal; that beat is kept.
- Output register:
  - Loads whenever out_valid==0 or out_ready==1.
  - It takes the head of the first non-empty FIFO at or after the RR pointer, then the pointer moves to granted+1 mod N_CH.
  - If no FIFO is non-empty, out_valid goes to 0.
  - While out_valid && !out_ready, all out_* fields hold stable.
- Latency:
  - A beat accepted at edge k is visible on out_* after edge k+1 if the output register is free. No same-cycle pass-through.
  - Sustained throughput is 1 beat/cycle total.
- FIFO: head/tail pointers have one extra wrap bit. full = DEPTH entries; empty = pointers equal.
- No channel starves: any non-empty FIFO is granted within N_CH output loads.

Optional Feature:
- RTP_CYCLE_STAMP_EN defined:
  - Adds output out_stamp[63:0].
  - Each FIFO entry also stores total_cycle at the push edge, and out_stamp presents it with the beat.
- Macro absent: no port, no storage.

Decomposition:
- Package rtp_collect_pkg:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - HIT_W=32, CNT_W=64, RCNT_W=32.
  - Struct rtp_result_t {hitT, ray_id[, stamp]}.
- Sub-module rtp_ch_fifo: one-channel synchronous FIFO (push/pop/full/empty/head), DEPTH-parametrised, instantiated N_CH times via generate.

Test Plan:
- Reset and idle: hold reset=0 3 cycles, release; ch_valid=all ones, no start -> ch_ready=0, all outputs 0, total_cycle stays 0.
- Single channel: N_CH=4, start, ch0 pushes hitT=0x3F800000 id=5, then ch_finish=4'hF, out_ready=1 -> out_* after +1 edge with out_ch=0, ray_count=1, done set, total_cycle frozen.
- Round-robin: all 4 channels push 2 beats simultaneously with out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3, ray_count=8.
- Backpressure/full: out_ready=0, ch1 pushes continuously -> ch_ready[1] drops after 8 accepts (DEPTH=8) plus 1 in the output register; out_* stable; release out_ready -> 9 beats in order.
- Finish with last beat and drain: ch2 asserts valid and finish in the same cycle while other channels are finished and out_ready=0 for 5 cycles -> state stays DRAIN until that beat handshakes, then done=1.
- Reset mid-run and restart: reset=0 during DRAIN with 3 buffered beats -> all cleared. Then start from DONE -> total_cycle and ray_count restart from 0.
